// File: rtl/turn_pkg.sv
// Shared types and helpers for the turn scheduler: FSM state encoding,
// the "no player" id and a population count used for end-of-game detection.
package turn_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        IN_TURN   = 3'd3,
        ADVANCE   = 3'd4,
        GAME_OVER = 3'd6
    } state_e;

    localparam int PLAYER_NONE = 0;

    // Number of set bits in a (zero-extended) mask of up to 32 players.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/next_alive_finder.sv
// Finds the first alive player after cur_id, scanning ids cyclically
// (MAX_PLAYER_CNT wraps to 1). cur_id itself is the last candidate, so with a
// single survivor the result is that survivor. wrap is set when the result is
// not above cur_id. next_id is 0 when nobody is alive.
module next_alive_finder #(
    parameter int MAX_PLAYER_CNT      = 7,
    parameter int LOG2_MAX_PLAYER_CNT = 3
) (
    input  logic [LOG2_MAX_PLAYER_CNT-1:0] cur_id,
    input  logic [MAX_PLAYER_CNT-1:0]      alive_mask,
    output logic [LOG2_MAX_PLAYER_CNT-1:0] next_id,
    output logic                           wrap
);

    logic [31:0] alive_ext;
    logic        found;
    int          pos;

    assign alive_ext = 32'(alive_mask);

    // Rotated priority scan: offset 1 first, offset MAX_PLAYER_CNT last.
    always_comb begin
        next_id = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 1; k <= MAX_PLAYER_CNT; k++) begin
            pos = (int'(cur_id) + k - 1) % MAX_PLAYER_CNT;
            if (!found && alive_ext[pos[4:0]]) begin
                found   = 1'b1;
                next_id = LOG2_MAX_PLAYER_CNT'(pos + 1);
            end
        end
        wrap = found && (next_id <= cur_id);
    end

endmodule

// File: rtl/turn_scheduler.sv
// Turn scheduler for Game_Player: sequences player turns, runs the per-step
// countdown and round counter, skips eliminated players and declares the
// game over (single survivor wins, no survivor or round limit is a draw).
// Optional: define TURN_SCHEDULER_PAUSE_EN to add a pause input that freezes
// the step countdown and withholds op_ready while held.
module turn_scheduler
    import turn_pkg::*;
#(
    parameter int MAX_PLAYER_CNT      = 7,
    parameter int LOG2_MAX_PLAYER_CNT = 3,
    parameter int MAX_STEP_TIME       = 15,
    parameter int LOG2_MAX_STEP_TIME  = 4,
    parameter int MAX_ROUND           = 999,
    parameter int LOG2_MAX_ROUND      = 12,
    parameter int TICKS_PER_SEC       = 50_000_000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [LOG2_MAX_PLAYER_CNT-1:0] first_player,
    input  logic [MAX_PLAYER_CNT-1:0]      alive_mask,
`ifdef TURN_SCHEDULER_PAUSE_EN
    input  logic                           pause,
`endif
    input  logic                           op_valid,
    output logic                           op_ready,
    output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
    output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
    output logic [LOG2_MAX_STEP_TIME-1:0]  step_timer,
    output logic [LOG2_MAX_ROUND-1:0]      round,
    output logic                           turn_start,
    output logic                           timeout,
    output logic [2:0]                     state,
    output logic                           game_over,
    output logic [LOG2_MAX_PLAYER_CNT-1:0] winner
);

    localparam int PW = LOG2_MAX_PLAYER_CNT;
    localparam int SW = LOG2_MAX_STEP_TIME;
    localparam int RW = LOG2_MAX_ROUND;
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] STEP_RELOAD = SW'(MAX_STEP_TIME);
    localparam logic [RW-1:0] ROUND_LAST  = RW'(MAX_ROUND);
    localparam logic [PW-1:0] PLAYER_MAX  = PW'(MAX_PLAYER_CNT);
    localparam logic [PW-1:0] NONE_ID     = PW'(PLAYER_NONE);

    state_e        state_q;
    logic [PW-1:0] cur_q, next_q, winner_q;
    logic [SW-1:0] timer_q;
    logic [RW-1:0] round_q;
    logic [TW-1:0] tick_q;
    logic          turn_start_q, timeout_q, game_over_q, op_ready_q;

    logic [31:0]   alive_ext;
    logic [4:0]    fp_idx, cur_idx;
    logic          start_ok, cur_alive, sec_tick, run, move_acc, last_alive;
    logic [PW-1:0] cand_id;
    logic          cand_wrap;
    logic [RW-1:0] round_d;

    assign alive_ext = 32'(alive_mask);
    assign fp_idx    = 5'(first_player) - 5'd1;
    assign cur_idx   = 5'(cur_q) - 5'd1;

    assign start_ok   = start && (first_player != NONE_ID) &&
                        (first_player <= PLAYER_MAX) && alive_ext[fp_idx];
    assign cur_alive  = alive_ext[cur_idx];
    assign sec_tick   = (tick_q == TICK_LAST);
    assign last_alive = (popcount(alive_ext) <= 6'd1);
    assign round_d    = (round_q == ROUND_LAST) ? round_q : round_q + 1'b1;

`ifdef TURN_SCHEDULER_PAUSE_EN
    assign run      = ~pause;
    assign op_ready = op_ready_q & ~pause;
`else
    assign run      = 1'b1;
    assign op_ready = op_ready_q;
`endif

    assign move_acc = op_valid && op_ready;

    next_alive_finder #(
        .MAX_PLAYER_CNT     (MAX_PLAYER_CNT),
        .LOG2_MAX_PLAYER_CNT(LOG2_MAX_PLAYER_CNT)
    ) u_finder (
        .cur_id    (cur_q),
        .alive_mask(alive_mask),
        .next_id   (cand_id),
        .wrap      (cand_wrap)
    );

    // Turn FSM with all outputs registered; next_player follows current_player
    // by one cycle and is forced to 0 whenever the FSM sits in IDLE/GAME_OVER.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            next_q       <= '0;
            winner_q     <= '0;
            timer_q      <= '0;
            round_q      <= '0;
            tick_q       <= '0;
            turn_start_q <= 1'b0;
            timeout_q    <= 1'b0;
            game_over_q  <= 1'b0;
            op_ready_q   <= 1'b0;
        end else begin
            turn_start_q <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    next_q <= '0;
                    if (start_ok) begin
                        state_q      <= IN_TURN;
                        cur_q        <= first_player;
                        timer_q      <= STEP_RELOAD;
                        round_q      <= RW'(1);
                        tick_q       <= '0;
                        turn_start_q <= 1'b1;
                        op_ready_q   <= 1'b1;
                    end
                end
                IN_TURN: begin
                    next_q <= cand_id;
                    // A committed move or a forfeit ends the turn before any
                    // tick is considered, so neither can raise timeout.
                    if (move_acc || !cur_alive) begin
                        state_q    <= ADVANCE;
                        op_ready_q <= 1'b0;
                    end else if (run) begin
                        if (sec_tick) begin
                            tick_q <= '0;
                            if (timer_q == SW'(1)) begin
                                timer_q    <= '0;
                                timeout_q  <= 1'b1;
                                state_q    <= ADVANCE;
                                op_ready_q <= 1'b0;
                            end else if (timer_q != '0) begin
                                timer_q <= timer_q - 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                ADVANCE: begin
                    if (last_alive) begin
                        // With at most one survivor the cyclic scan lands on it.
                        state_q     <= GAME_OVER;
                        game_over_q <= 1'b1;
                        winner_q    <= cand_id;
                        next_q      <= '0;
                    end else if (cand_wrap && (round_d == ROUND_LAST)) begin
                        state_q     <= GAME_OVER;
                        game_over_q <= 1'b1;
                        winner_q    <= NONE_ID;
                        round_q     <= ROUND_LAST;
                        next_q      <= '0;
                    end else begin
                        state_q      <= IN_TURN;
                        cur_q        <= cand_id;
                        next_q       <= cand_id;
                        if (cand_wrap) begin
                            round_q <= round_d;
                        end
                        timer_q      <= STEP_RELOAD;
                        tick_q       <= '0;
                        turn_start_q <= 1'b1;
                        op_ready_q   <= 1'b1;
                    end
                end
                GAME_OVER: begin
                    next_q      <= '0;
                    game_over_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state          = state_q;
    assign current_player = cur_q;
    assign next_player    = next_q;
    assign step_timer     = timer_q;
    assign round          = round_q;
    assign turn_start     = turn_start_q;
    assign timeout        = timeout_q;
    assign game_over      = game_over_q;
    assign winner         = winner_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: directed scenarios followed by randomized games,
// every cycle checked against a behavioural model that tracks turn age in
// cycles rather than a tick counter.
module tb_turn_scheduler;

    localparam int N    = 7;
    localparam int PW   = 3;
    localparam int MAXS = 15;
    localparam int SW   = 4;
    localparam int MAXR = 3;
    localparam int RW   = 12;
    localparam int TPS  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] first_player = '0;
    logic [N-1:0]  alive_mask = '0;
    logic          op_valid = 1'b0;
`ifdef TURN_SCHEDULER_PAUSE_EN
    logic          pause = 1'b0;
`endif
    logic          op_ready;
    logic [PW-1:0] current_player, next_player, winner;
    logic [SW-1:0] step_timer;
    logic [RW-1:0] round;
    logic          turn_start, timeout, game_over;
    logic [2:0]    state;

    always #5 clock = ~clock;

    turn_scheduler #(
        .MAX_PLAYER_CNT     (N),
        .LOG2_MAX_PLAYER_CNT(PW),
        .MAX_STEP_TIME      (MAXS),
        .LOG2_MAX_STEP_TIME (SW),
        .MAX_ROUND          (MAXR),
        .LOG2_MAX_ROUND     (RW),
        .TICKS_PER_SEC      (TPS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .first_player  (first_player),
        .alive_mask    (alive_mask),
`ifdef TURN_SCHEDULER_PAUSE_EN
        .pause         (pause),
`endif
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .current_player(current_player),
        .next_player   (next_player),
        .step_timer    (step_timer),
        .round         (round),
        .turn_start    (turn_start),
        .timeout       (timeout),
        .state         (state),
        .game_over     (game_over),
        .winner        (winner)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", tag, n_cyc, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 in turn, 2 advance, 3 game over
    int m_ph = 0, m_cur = 0, m_next = 0, m_timer = 0, m_round = 0, m_age = 0, m_win = 0;
    bit m_ts = 0, m_to = 0, m_over = 0;
    int ph_code[4] = '{0, 3, 4, 6};

    function automatic bit is_alive(input logic [N-1:0] m, input int id);
        if (id < 1 || id > N) return 1'b0;
        return ((int'(m) >> (id - 1)) & 1) == 1;
    endfunction

    function automatic int next_alive(input int cur, input logic [N-1:0] m);
        for (int off = 1; off <= N; off++) begin
            int id;
            id = ((cur + off - 1) % N) + 1;
            if (is_alive(m, id)) return id;
        end
        return 0;
    endfunction

    function automatic int alive_count(input logic [N-1:0] m);
        int c = 0;
        for (int id = 1; id <= N; id++) if (is_alive(m, id)) c++;
        return c;
    endfunction

    task automatic model_step();
        int old_ph, old_cur, cand, r;
        old_ph  = m_ph;
        old_cur = m_cur;
        if (reset) begin
            m_ph = 0; m_cur = 0; m_next = 0; m_timer = 0; m_round = 0;
            m_age = 0; m_win = 0; m_ts = 0; m_to = 0; m_over = 0;
            return;
        end
        m_ts = 0;
        m_to = 0;
        case (m_ph)
            0: begin
                if (start && is_alive(alive_mask, int'(first_player))) begin
                    m_ph = 1; m_cur = int'(first_player); m_timer = MAXS;
                    m_round = 1; m_age = 0; m_ts = 1;
                end
            end
            1: begin
                if (op_valid) m_ph = 2;
                else if (!is_alive(alive_mask, m_cur)) m_ph = 2;
                else begin
                    m_age++;
                    m_timer = MAXS - m_age / TPS;
                    if (m_timer == 0) begin
                        m_to = 1;
                        m_ph = 2;
                    end
                end
            end
            2: begin
                if (alive_count(alive_mask) <= 1) begin
                    m_ph = 3; m_over = 1; m_win = next_alive(0, alive_mask);
                end else begin
                    cand = next_alive(m_cur, alive_mask);
                    r = m_round + ((cand <= m_cur) ? 1 : 0);
                    if (cand <= m_cur && r >= MAXR) begin
                        m_ph = 3; m_over = 1; m_win = 0; m_round = MAXR;
                    end else begin
                        m_round = r; m_cur = cand; m_timer = MAXS;
                        m_age = 0; m_ph = 1; m_ts = 1;
                    end
                end
            end
            default: ;
        endcase
        if (m_ph == 0 || m_ph == 3) m_next = 0;
        else if (old_ph == 1 || old_ph == 2) m_next = next_alive(old_cur, alive_mask);
        else m_next = 0;
    endtask

    task automatic check_all();
        chk("state",          32'(state),          32'(ph_code[m_ph]));
        chk("current_player", 32'(current_player), 32'(m_cur));
        chk("next_player",    32'(next_player),    32'(m_next));
        chk("step_timer",     32'(step_timer),     32'(m_timer));
        chk("round",          32'(round),          32'(m_round));
        chk("turn_start",     32'(turn_start),     32'(m_ts));
        chk("timeout",        32'(timeout),        32'(m_to));
        chk("game_over",      32'(game_over),      32'(m_over));
        chk("winner",         32'(winner),         32'(m_win));
        chk("op_ready",       32'(op_ready),       32'(m_ph == 1));
    endtask

    // One clock: drive on the falling edge, step model on the rising edge,
    // compare shortly after.
    task automatic cyc(input bit r, input bit s, input int fp, input logic [N-1:0] m,
                       input bit op);
        @(negedge clock);
        reset        = r;
        start        = s;
        first_player = PW'(fp);
        alive_mask   = m;
        op_valid     = op;
        @(posedge clock);
        model_step();
        n_cyc++;
        #1;
        check_all();
    endtask

    initial begin
        logic [N-1:0] m;
        int fp, opdiv, tail;
        bit r, s, op;

        // Reset state, then refused starts (player 0, dead player).
        cyc(1, 0, 0, 7'b0000000, 0);
        cyc(1, 0, 0, 7'b0000000, 0);
        cyc(0, 1, 0, 7'b1111111, 0);
        cyc(0, 1, 3, 7'b0000011, 0);
        // Start with player 2, then a move hands over to player 1 (round 2).
        cyc(0, 1, 2, 7'b0000011, 0);
        repeat (3) cyc(0, 0, 2, 7'b0000011, 0);
        cyc(0, 0, 2, 7'b0000011, 1);
        cyc(0, 0, 2, 7'b0000011, 0);
        // Player 1 times out after 60 cycles; player 2 follows.
        repeat (61) cyc(0, 0, 2, 7'b0000011, 0);
        // Move coinciding with the final tick; this wrap reaches the round limit.
        repeat (59) cyc(0, 0, 2, 7'b0000011, 0);
        cyc(0, 0, 2, 7'b0000011, 1);
        repeat (4) cyc(0, 1, 2, 7'b0000011, 1);

        // Elimination: player 2 wins, start ignored afterwards.
        cyc(1, 0, 0, 7'b0000011, 0);
        cyc(0, 1, 1, 7'b0000011, 0);
        repeat (5) cyc(0, 0, 1, 7'b0000011, 0);
        cyc(0, 0, 1, 7'b0000010, 0);
        repeat (4) cyc(0, 1, 1, 7'b0000010, 0);

        // Reset in the middle of a turn.
        cyc(1, 0, 0, 7'b0000111, 0);
        cyc(0, 1, 3, 7'b0000111, 0);
        repeat (10) cyc(0, 0, 3, 7'b0000111, 0);
        cyc(1, 0, 3, 7'b0000111, 0);
        cyc(0, 0, 3, 7'b0000111, 0);

        // Randomized games.
        while (n_cyc < 20000) begin
            cyc(1, 0, 0, 7'b0000000, 0);
            m = 7'($urandom_range(1, 127));
            if ($urandom_range(0, 3) == 0)
                m = 7'((1 << $urandom_range(0, 6)) | (1 << $urandom_range(0, 6)));
            fp = $urandom_range(0, 7);
            case ($urandom_range(0, 2))
                0: opdiv = 2;
                1: opdiv = 8;
                default: opdiv = 90;
            endcase
            tail = 0;
            for (int k = 0; k < 600 && tail < 4; k++) begin
                if (m_ph == 0 && $urandom_range(0, 4) == 0) fp = $urandom_range(0, 7);
                s  = ($urandom_range(0, 2) == 0);
                op = ($urandom_range(1, opdiv) == 1);
                if ($urandom_range(0, 59) == 0) m = m & ~7'(1 << $urandom_range(0, 6));
                r  = ($urandom_range(0, 699) == 0);
                cyc(r, s, fp, m, op);
                if (m_ph == 3 || (m_ph == 0 && m == 0)) tail++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Sequences player turns for Game_Player: selects the current and next player and runs the per-step countdown timer and round counter.
- Accepts "move committed" handshakes from the game logic, skips eliminated players and declares game over (win or draw).
- Runs on the game-logic clock (clk_50M domain); Game_Player feeds it the alive mask and consumes its turn state.

Parameters:
MAX_PLAYER_CNT, 7, number of players (ids 1..MAX_PLAYER_CNT; 0 = NPC/none)
LOG2_MAX_PLAYER_CNT, 3, width of player ids ($clog2(MAX_PLAYER_CNT+1))
MAX_STEP_TIME, 15, seconds allowed per step
LOG2_MAX_STEP_TIME, 4, step_timer width
MAX_ROUND, 999, round at which the game ends in a draw
LOG2_MAX_ROUND, 12, round width
TICKS_PER_SEC, 50_000_000, clock cycles per second (bench uses 4)

Ports:
clock  in  1  game-logic clock
reset  in  1  synchronous reset, active-high
start  in  1  begin game (level; sampled in IDLE)
first_player  in  LOG2_MAX_PLAYER_CNT  starting player id
alive_mask  in  MAX_PLAYER_CNT  bit i=1: player i+1 still alive
op_valid  in  1  current player commits a move
op_ready  out  1  scheduler accepts a move (1 only in IN_TURN)
current_player  out  LOG2_MAX_PLAYER_CNT  player whose turn it is
next_player  out  LOG2_MAX_PLAYER_CNT  next alive player after current
step_timer  out  LOG2_MAX_STEP_TIME  seconds remaining
round  out  LOG2_MAX_ROUND  current round, 1-based
turn_start  out  1  one-cycle pulse on entry to each turn
timeout  out  1  one-cycle pulse when a step expires
state  out  3  FSM state encoding
game_over  out  1  sticky end flag
winner  out  LOG2_MAX_PLAYER_CNT  winner id; 0 = draw

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; current_player, next_player, step_timer, round, winner, turn_start, timeout, game_over, op_ready all 0; internal tick counter 0. Reset asserted in any state restores these values at the next edge.
- States: IDLE=0, IN_TURN=3, ADVANCE=4, GAME_OVER=6.
- IDLE:
  - start=1, first_player in 1..MAX_PLAYER_CNT, and that player alive -> IN_TURN.
  - On that entry: current_player=first_player, step_timer=MAX_STEP_TIME, round=1, tick counter=0, turn_start=1.
  - Otherwise stay in IDLE.
- IN_TURN:
  - Tick counter counts 0..TICKS_PER_SEC-1 and wraps; sec_tick fires at count TICKS_PER_SEC-1, so the first tick comes TICKS_PER_SEC cycles after entry.
  - On sec_tick, step_timer decrements.
  - On sec_tick with step_timer==1: step_timer becomes 0, timeout=1, go to ADVANCE. Timeout therefore lands MAX_STEP_TIME*TICKS_PER_SEC cycles after entry.
  - op_valid && op_ready -> ADVANCE, no timeout pulse. If a move and the final tick coincide, the move wins and timeout stays 0.
  - current player's alive bit drops -> ADVANCE next edge (forfeit), no timeout pulse.
- ADVANCE (exactly one cycle, evaluated in priority order):
  1. popcount(alive_mask)<=1 -> GAME_OVER; winner = id of the alive player, or 0 if none.
  2. Cand = first alive id after current_player, scanning cyclically (MAX_PLAYER_CNT wraps to 1). If cand<=current_player (wrap), round increments. If the incremented round reaches MAX_ROUND -> GAME_OVER with winner=0.
  3. Otherwise -> IN_TURN with current_player=cand, step_timer reloaded, tick counter cleared, turn_start=1.
- GAME_OVER: game_over=1; all other outputs hold; start and op_valid are ignored; only reset exits.
- next_player is registered: recomputed every cycle from current_player and alive_mask (1-cycle latency). It is 0 in IDLE and GAME_OVER.
- turn_start and timeout are each high for exactly one cycle per event.
- Widths: round saturates at MAX_ROUND and never wraps. step_timer never underflows.

Optional Feature:
- Macro: TURN_SCHEDULER_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1 in IN_TURN, the tick counter and step_timer freeze and op_ready=0. Alive-mask forfeit still applies. Counting resumes from the frozen value.
- Undefined: no pause port; the timer always runs.

Decomposition:
- Package turn_pkg holds:
  - state enum (IDLE, IN_TURN, ADVANCE, GAME_OVER) with the fixed encodings above;
  - PLAYER_NONE=0 constant;
  - a popcount function.
- Sub-module next_alive_finder (combinational rotate-and-priority-encode): inputs current id and alive_mask; outputs next id and wrap flag. Used both for ADVANCE and for next_player.

Test Plan:
- Start: reset, then start=1, first_player=2, alive_mask=7'b0000011 -> next cycle state=3, current_player=2, step_timer=15, round=1, turn_start high 1 cycle, next_player=1 one cycle later.
- Move handshake: in player 2's turn, pulse op_valid -> ADVANCE one cycle, then current_player=1, round=2, step_timer=15, turn_start pulse, no timeout.
- Timeout (TICKS_PER_SEC=4): no op_valid -> step_timer steps 15..1 every 4 cycles; timeout pulses at 60 cycles after entry; next turn starts 1 cycle later.
- Coincident move: op_valid on the cycle of the final sec_tick -> advance occurs with timeout=0.
- Elimination: in player 1's turn, alive_mask becomes 7'b0000010 -> ADVANCE, then state=6, game_over=1, winner=2; start has no effect afterwards.
- Draw and reset: MAX_ROUND=3, two alive players trading moves -> GAME_OVER with winner=0 once round would reach 3. A reset mid-IN_TURN returns all outputs to 0 and state to IDLE next edge.
